hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing and hazard unit for the Filter-GPU five-stage vector datapath (fetch, decode, execute, memory, writeback; 3 lanes × 18 bits). It starts and stops kernel execution, generates the stage hold/flush strobes and the execute-stage forwarding selects, freezes the pipeline during multi-cycle data-memory accesses, and drains the pipeline on a halt instruction. It sits beside the datapath and drives its CLR/EN/Forward inputs.

## Interface
Parameters:
- REG_W, 4, register-address width
- MEM_LAT, 2, extra wait cycles per data-memory access in M (0 = single-cycle memory)
- CNT_W, 16, stall-counter width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin kernel execution (sampled in IDLE only)
- halt_instr  in  1  halt opcode present in decode
- RA1D, RA2D  in  REG_W  decode source registers
- RA1E, RA2E  in  REG_W  execute source registers
- WA3E, WA3M, WA3W  in  REG_W  destination register per stage
- MemtoRegE  in  1  load in execute
- RegWriteM, RegWriteW  in  1  register write pending in M / W
- MemAccessM  in  1  load or store in M
- mem_ready  in  1  data memory completes access
- EN1  out  1  fetch hold (1 = PC holds)
- EN2  out  1  decode-buffer hold
- EN3  out  1  execute/memory/writeback-buffer hold
- CLR1  out  1  decode-buffer flush (bubble)
- CLR2  out  1  execute-buffer flush (bubble)
- ForwardAE, ForwardBE  out  2  SrcA/SrcB select: 00 register file, 01 ResultW, 10 ALUResultM
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of kernel
- stall_cnt  out  CNT_W  stall cycles since last start, saturating

## Operation
- States: IDLE, RUN, MEMWAIT, DRAIN, DONE.
- IDLE: EN1=EN2=EN3=1, CLR1=CLR2=1. start=1 → RUN; stall_cnt cleared on that edge.
- RUN: EN3=0. Hazard outputs are combinational from inputs:
  - Load-use: MemtoRegE && (RA1D==WA3E || RA2D==WA3E) → EN1=EN2=1, CLR2=1, stall_cnt+1.
  - Otherwise EN1=EN2=CLR1=CLR2=0.
  - Forwarding per source (A uses RA1E, B uses RA2E): RegWriteM && WA3M==src → 10; else RegWriteW && WA3W==src → 01; else 00. M has priority over W.
  - Transitions, in priority order: MemAccessM && MEM_LAT>0 → MEMWAIT, wait counter loaded with MEM_LAT−1; halt_instr → DRAIN, drain counter loaded with 2; else stay in RUN.
- MEMWAIT: EN1=EN2=EN3=1, CLR1=CLR2=0, forwarding held at 00, stall_cnt+1 each cycle. Exit to RUN when the wait counter is 0 and mem_ready=1; otherwise decrement the counter, holding at 0. An asserted halt_instr is ignored and re-evaluated after return to RUN.
- DRAIN: EN1=EN2=1, CLR1=1, CLR2=1, EN3=0; forwarding still active. Counter 0 → DONE; else decrement. A MemAccessM in DRAIN still enters MEMWAIT, with the drain count preserved and resumed afterwards.
- DONE: done=1, all holds/clears as in IDLE; → IDLE next cycle.
- stall_cnt saturates at 2^CNT_W−1 and never wraps.
- start outside IDLE is ignored.

## Timing
- Reset (asynchronous): state IDLE, counters 0, stall_cnt 0, done 0, busy 0. Combinationally during reset: EN1=EN2=EN3=1, CLR1=CLR2=1, ForwardAE=ForwardBE=00.
- Reset mid-MEMWAIT or mid-DRAIN aborts immediately with no done pulse.
- start high at edge k: RUN from cycle k+1, busy=1 at k+1.
- Load-use stall: exactly one bubble cycle per load-use pair, provided the load is not followed by a memory freeze.
- MEMWAIT lasts max(MEM_LAT, first cycle with mem_ready after the count expires) cycles.
- halt_instr sampled in RUN at edge k: DRAIN during k+1..k+3, done=1 at cycle k+4, IDLE at k+5.
- done and busy are registered outputs decoded from state. Hold, clear and forward outputs are combinational, and settle within the cycle.

## Structure
- Package filter_gpu_pkg: state enum ctrl_state_t (IDLE, RUN, MEMWAIT, DRAIN, DONE) and the forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module forward_unit: purely combinational, instantiated twice, once for A and once for B. Inputs are the source register, WA3M, WA3W, RegWriteM and RegWriteW; output is the 2-bit select. The FSM, counters and stall logic live in the top module.

## Test plan
- Reset, then start pulse → IDLE outputs all 1/00 until start; busy=1 the next cycle; EN1=EN2=EN3=CLR1=CLR2=0 with no hazards.
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. With RegWriteM=0 → 01. RA2E=5 unmatched → ForwardBE=00.
- MemtoRegE=1, WA3E=4, RA2D=4 → one cycle of EN1=EN2=CLR2=1, then normal; stall_cnt=1.
- MEM_LAT=2, MemAccessM pulse, mem_ready held low for 3 cycles then high → EN3=1 for 4 cycles; return to RUN; stall_cnt +4.
- halt_instr in RUN at cycle 10 → CLR1=1 during cycles 11–13; done=1 only at cycle 14; busy=0 at 15.
- RST asserted during MEMWAIT → outputs go to reset values within the same cycle; no done pulse; a subsequent start runs normally.

Source files
------------

// File: rtl/filter_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_gpu_pkg
// Purpose  : Shared types and constants for the Filter-GPU pipeline control:
//            sequencer state encoding and execute-stage forward selects.
// Revision : 1.0 - initial release
// ============================================================================
package filter_gpu_pkg;

  // Sequencer states for kernel execution.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    MEMWAIT = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } ctrl_state_t;

  // Execute-stage operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_unit
// Purpose  : Combinational operand-forwarding select for one execute-stage
//            source register. The memory-stage result is the younger value,
//            so it wins over the writeback-stage result.
// Revision : 1.0 - initial release
// ============================================================================
module forward_unit
  import filter_gpu_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src_reg,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [1:0]       fwd_sel
);

  // Pick the youngest pending writer of src_reg, else the register file.
  always_comb begin
    fwd_sel = FWD_RF;
    if (RegWriteM && (WA3M == src_reg)) begin
      fwd_sel = FWD_MEM;
    end else if (RegWriteW && (WA3W == src_reg)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Kernel sequencer and hazard unit for the five-stage vector
//            datapath. Starts/stops execution, produces stage hold/flush
//            strobes and forward selects, freezes the pipe during slow
//            data-memory accesses and drains it on a halt instruction.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
  import filter_gpu_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             halt_instr,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             MemtoRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  output logic             EN1,
  output logic             EN2,
  output logic             EN3,
  output logic             CLR1,
  output logic             CLR2,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stall_cnt
);

  // One countdown register serves both the memory wait and the drain; it
  // must hold the larger of MEM_LAT-1 and the drain length of 2.
  localparam int               SEQ_MAX    = (MEM_LAT > 3) ? MEM_LAT : 3;
  localparam int               SEQ_W      = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] WAIT_LOAD  = SEQ_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
  localparam logic [SEQ_W-1:0] DRAIN_LOAD = SEQ_W'(2);
  localparam bit               MEM_MULTI  = (MEM_LAT > 0);

  ctrl_state_t      state_q, state_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [SEQ_W-1:0] drain_save_q, drain_save_d;
  logic             resume_drain_q, resume_drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             load_use;
  logic             stall_inc;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  forward_unit #(.REG_W(REG_W)) u_fwd_a (
    .src_reg   (RA1E),
    .WA3M      (WA3M),
    .WA3W      (WA3W),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_sel   (fwd_a)
  );

  forward_unit #(.REG_W(REG_W)) u_fwd_b (
    .src_reg   (RA2E),
    .WA3M      (WA3M),
    .WA3W      (WA3W),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_sel   (fwd_b)
  );

  // A load in execute whose destination feeds a decode source needs a bubble.
  assign load_use  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign stall_inc = ((state_q == RUN) && load_use) || (state_q == MEMWAIT);

  // Hold/flush strobes and forward selects, decoded from state and hazards.
  always_comb begin
    EN1       = 1'b1;
    EN2       = 1'b1;
    EN3       = 1'b1;
    CLR1      = 1'b1;
    CLR2      = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    case (state_q)
      RUN: begin
        EN3       = 1'b0;
        CLR1      = 1'b0;
        EN1       = load_use;
        EN2       = load_use;
        CLR2      = load_use;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
      end
      MEMWAIT: begin
        CLR1 = 1'b0;
        CLR2 = 1'b0;
      end
      DRAIN: begin
        EN3       = 1'b0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
      end
      default: ;
    endcase
  end

  // Next-state, countdown and stall-counter logic.
  always_comb begin
    state_d        = state_q;
    seq_cnt_d      = seq_cnt_q;
    drain_save_d   = drain_save_q;
    resume_drain_d = resume_drain_q;
    stall_cnt_d    = stall_cnt_q;

    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end
      end
      RUN: begin
        if (MEM_MULTI && MemAccessM) begin
          state_d        = MEMWAIT;
          seq_cnt_d      = WAIT_LOAD;
          resume_drain_d = 1'b0;
        end else if (halt_instr) begin
          state_d   = DRAIN;
          seq_cnt_d = DRAIN_LOAD;
        end
      end
      MEMWAIT: begin
        if ((seq_cnt_q == '0) && mem_ready) begin
          resume_drain_d = 1'b0;
          if (resume_drain_q) begin
            state_d   = DRAIN;
            seq_cnt_d = drain_save_q;
          end else begin
            state_d = RUN;
          end
        end else if (seq_cnt_q != '0) begin
          seq_cnt_d = seq_cnt_q - SEQ_W'(1);
        end
      end
      DRAIN: begin
        // A memory access mid-drain parks the drain count until it completes.
        if (MEM_MULTI && MemAccessM) begin
          state_d        = MEMWAIT;
          drain_save_d   = seq_cnt_q;
          resume_drain_d = 1'b1;
          seq_cnt_d      = WAIT_LOAD;
        end else if (seq_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          seq_cnt_d = seq_cnt_q - SEQ_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      seq_cnt_q      <= '0;
      drain_save_q   <= '0;
      resume_drain_q <= 1'b0;
      stall_cnt_q    <= '0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_cnt_q      <= seq_cnt_d;
      drain_save_q   <= drain_save_d;
      resume_drain_q <= resume_drain_d;
      stall_cnt_q    <= stall_cnt_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Self-checking bench for hazard_controller: vector table for the
//            RUN-state hazard/forward decode, hand sequences for memory
//            freeze, drain and reset, and a randomized run against a
//            rule-level model of forwarding, bubbles and stall counting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;
  import filter_gpu_pkg::*;

  localparam int REG_W     = 4;
  localparam int MEM_LAT   = 2;
  localparam int CNT_W     = 6;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start, halt_instr;
  logic [REG_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             MemtoRegE, RegWriteM, RegWriteW, MemAccessM, mem_ready;
  logic             EN1, EN2, EN3, CLR1, CLR2, busy, done;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt;

  logic [4:0] ctl_o;
  logic [3:0] fwd_o;
  assign ctl_o = {EN1, EN2, EN3, CLR1, CLR2};
  assign fwd_o = {ForwardAE, ForwardBE};

  hazard_controller #(.REG_W(REG_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .halt_instr(halt_instr),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .EN1(EN1), .EN2(EN2), .EN3(EN3), .CLR1(CLR1), .CLR2(CLR2),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int exp_stall = 0;

  typedef struct {
    string      nm;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       m2r, rwm, rww;
    logic [4:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic mid();  @(negedge CLK);     endtask

  task automatic clear_inputs();
    start = 0; halt_instr = 0; MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0;
    MemAccessM = 0; mem_ready = 0;
    RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd15; WA3M = 4'd14; WA3W = 4'd13;
  endtask

  function automatic vec_t mk(string nm, int ra1d, int ra2d, int ra1e, int ra2e,
                              int wa3e, int wa3m, int wa3w, int m2r, int rwm, int rww,
                              int ctl, int fa, int fb);
    vec_t v;
    v.nm = nm; v.ra1d = 4'(ra1d); v.ra2d = 4'(ra2d); v.ra1e = 4'(ra1e); v.ra2e = 4'(ra2e);
    v.wa3e = 4'(wa3e); v.wa3m = 4'(wa3m); v.wa3w = 4'(wa3w);
    v.m2r = 1'(m2r); v.rwm = 1'(rwm); v.rww = 1'(rww);
    v.ctl = 5'(ctl); v.fa = 2'(fa); v.fb = 2'(fb);
    return v;
  endfunction

  // Rule-level reference: youngest pending writer wins, else register file.
  function automatic int fwd_ref(int src, int wm, int ww, int rwm, int rww);
    if (rwm != 0 && wm == src) return 2;
    if (rww != 0 && ww == src) return 1;
    return 0;
  endfunction

  function automatic int exp_wait_len(int dly);
    return (MEM_LAT > dly + 1) ? MEM_LAT : dly + 1;
  endfunction

  function automatic void add_stall(int n);
    exp_stall = (exp_stall + n > STALL_MAX) ? STALL_MAX : exp_stall + n;
  endfunction

  task automatic rand_fwd_inputs();
    RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
    WA3M = 4'($urandom_range(0, 3)); WA3W = 4'($urandom_range(0, 3));
    RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_fwd(input string nm);
    chk(nm, fwd_o, fwd_ref(RA1E, WA3M, WA3W, RegWriteM, RegWriteW) * 4 +
                   fwd_ref(RA2E, WA3M, WA3W, RegWriteM, RegWriteW));
  endtask

  // Count freeze cycles; ends mid-cycle in the first cycle after the freeze.
  task automatic wait_loop(input int dly, output int len);
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    len = 0;
    for (int n = 0; n < 40; n++) begin
      mem_ready = (n >= dly);
      mid();
      if (!EN3) break;
      len++;
      chk("memwait_ctl", ctl_o, 5'b11100);
      chk("memwait_fwd", fwd_o, 0);
      tick();
    end
    chk("wait_exit_fwd", ForwardAE, FWD_MEM);
    mem_ready = 1'b0; RA1E = 4'd0; WA3M = 4'd14; RegWriteM = 1'b0;
    #1;
  endtask

  task automatic mem_wait(input int dly);
    int len;
    MemAccessM = 1'b1;
    mid();
    chk("memreq_ctl", ctl_o, 0);
    tick();
    MemAccessM = 1'b0;
    wait_loop(dly, len);
    chk("memwait_len", len, exp_wait_len(dly));
    add_stall(exp_wait_len(dly));
    chk("memwait_exit_ctl", ctl_o, 0);
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    mid();
    chk("start_idle_busy", busy, 0);
    chk("start_idle_ctl", ctl_o, 5'b11111);
    tick();
    start = 1'b0;
    mid();
    chk("start_busy", busy, 1);
    chk("start_run_ctl", ctl_o, 0);
    chk("start_stall_clr", stall_cnt, 0);
    exp_stall = 0;
    tick();
  endtask

  // mode 0: plain halt; 1: memory access in first drain cycle;
  // 2: halt raised while frozen, taken only after return to RUN.
  task automatic do_halt(input int mode, input int dly);
    int len;
    if (mode == 2) begin
      MemAccessM = 1'b1;
      mid();
      chk("h2_memreq_ctl", ctl_o, 0);
      tick();
      MemAccessM = 1'b0;
      halt_instr = 1'b1;
      wait_loop(dly, len);
      chk("h2_wait_len", len, exp_wait_len(dly));
      add_stall(exp_wait_len(dly));
    end else begin
      halt_instr = 1'b1;
      mid();
    end
    chk("halt_run_ctl", ctl_o, 0);
    tick();
    halt_instr = 1'b0;
    if (mode == 1) begin
      MemAccessM = 1'b1;
      mid();
      chk("h1_drain_mem_ctl", ctl_o, 5'b11011);
      tick();
      MemAccessM = 1'b0;
      wait_loop(dly, len);
      chk("h1_wait_len", len, exp_wait_len(dly));
      add_stall(exp_wait_len(dly));
    end
    for (int i = 0; i < 3; i++) begin
      rand_fwd_inputs();
      if (mode == 1 && i == 0) #1; else mid();
      chk("drain_ctl", ctl_o, 5'b11011);
      chk("drain_busy", busy, 1);
      chk("drain_done", done, 0);
      chk_fwd("drain_fwd");
      tick();
    end
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    mid();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_ctl", ctl_o, 5'b11111);
    chk("done_fwd", fwd_o, 0);
    chk("done_stall", stall_cnt, exp_stall);
    tick();
    clear_inputs();
    mid();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    tick();
  endtask

  initial begin
    vec_t vt[11];
    int   sel, dly;
    logic lu;

    clear_inputs();
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    #1 RST = 1'b1;
    #1;
    chk("rst_ctl", ctl_o, 5'b11111);
    chk("rst_fwd", fwd_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("idle_ctl", ctl_o, 5'b11111);
      chk("idle_fwd", fwd_o, 0);
      chk("idle_busy", busy, 0);
      tick();
    end
    clear_inputs();
    do_start();

    //               nm            ra1d ra2d ra1e ra2e wa3e wa3m wa3w m2r rwm rww ctl fa fb
    vt[0]  = mk("no_hazard",     1, 2, 3, 5, 8, 9, 10, 0, 1, 1, 0, 0, 0);
    vt[1]  = mk("fwd_m_prio",    1, 2, 3, 5, 8, 3, 3,  0, 1, 1, 0, 2, 0);
    vt[2]  = mk("fwd_w",         1, 2, 3, 5, 8, 3, 3,  0, 0, 1, 0, 1, 0);
    vt[3]  = mk("fwd_b_w",       1, 2, 2, 7, 8, 7, 7,  0, 0, 1, 0, 0, 1);
    vt[4]  = mk("fwd_both_m",    1, 2, 9, 9, 8, 9, 4,  0, 1, 1, 0, 2, 2);
    vt[5]  = mk("fwd_no_write",  1, 2, 3, 5, 8, 3, 5,  0, 0, 0, 0, 0, 0);
    vt[6]  = mk("lu_rb",         1, 4, 0, 0, 4, 11, 12, 1, 0, 0, 25, 0, 0);
    vt[7]  = mk("no_lu_nonload", 4, 4, 0, 0, 4, 11, 12, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk("lu_ra",         6, 1, 0, 0, 6, 11, 12, 1, 0, 0, 25, 0, 0);
    vt[9]  = mk("load_no_dep",   1, 2, 0, 0, 7, 11, 12, 1, 0, 0, 0, 0, 0);
    vt[10] = mk("fwd_split",     1, 2, 5, 6, 8, 6, 5,  0, 1, 1, 0, 1, 2);
    foreach (vt[i]) begin
      RA1D = vt[i].ra1d; RA2D = vt[i].ra2d; RA1E = vt[i].ra1e; RA2E = vt[i].ra2e;
      WA3E = vt[i].wa3e; WA3M = vt[i].wa3m; WA3W = vt[i].wa3w;
      MemtoRegE = vt[i].m2r; RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
      mid();
      chk({vt[i].nm, "_ctl"}, ctl_o, vt[i].ctl);
      chk({vt[i].nm, "_fa"}, ForwardAE, vt[i].fa);
      chk({vt[i].nm, "_fb"}, ForwardBE, vt[i].fb);
      if (vt[i].ctl == 5'b11001) add_stall(1);
      tick();
    end
    clear_inputs();
    mid();
    chk("table_stall", stall_cnt, 2);
    tick();

    // Single load-use pair: one bubble, then normal flow.
    MemtoRegE = 1'b1; WA3E = 4'd4; RA2D = 4'd4;
    mid();
    chk("lu_bubble_ctl", ctl_o, 5'b11001);
    tick();
    clear_inputs();
    add_stall(1);
    mid();
    chk("lu_after_ctl", ctl_o, 0);
    chk("lu_stall", stall_cnt, exp_stall);
    tick();

    // start outside IDLE must not restart or clear the stall count.
    start = 1'b1;
    tick();
    start = 1'b0;
    mid();
    chk("start_ignored_stall", stall_cnt, exp_stall);
    chk("start_ignored_ctl", ctl_o, 0);
    tick();

    // Memory freeze: ready low for three cycles then high.
    mem_wait(3);
    mid();
    chk("memwait_stall", stall_cnt, exp_stall);
    tick();

    do_halt(0, 0);
    do_start();
    do_halt(1, 1);
    do_start();
    do_halt(2, 0);
    do_start();

    // Randomized RUN traffic against the rule model; long enough to saturate.
    for (int it = 0; it < 120; it++) begin
      clear_inputs();
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        dly = $urandom_range(0, 5);
        mem_wait(dly);
      end else begin
        RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
        WA3E = 4'($urandom_range(0, 3)); MemtoRegE = 1'($urandom_range(0, 1));
        rand_fwd_inputs();
        lu = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
        mid();
        chk("rand_ctl", ctl_o, lu ? 5'b11001 : 5'b00000);
        chk_fwd("rand_fwd");
        if (lu) add_stall(1);
        tick();
      end
      clear_inputs();
      mid();
      chk("rand_stall", stall_cnt, exp_stall);
      tick();
    end
    chk("stall_saturated", stall_cnt, STALL_MAX);

    // Reset during a memory freeze aborts at once with no done pulse.
    MemAccessM = 1'b1;
    tick();
    MemAccessM = 1'b0;
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    mid();
    chk("pre_rst_memwait", EN3, 1);
    tick();
    RST = 1'b1;
    #1;
    chk("rst_mw_ctl", ctl_o, 5'b11111);
    chk("rst_mw_fwd", fwd_o, 0);
    chk("rst_mw_busy", busy, 0);
    chk("rst_mw_stall", stall_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rst_mw_nodone", done, 0);
      tick();
    end
    RST = 1'b0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("post_rst_nodone", done, 0);
      chk("post_rst_busy", busy, 0);
      tick();
    end
    do_start();
    do_halt(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the sequence ever stalls on a clock wait.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion", tests);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
